// File: rtl/fifo_order_checker.sv
// ---------------------------------------------------------------------------
// fifo_order_checker
//
// In-order scoreboard for a FIFO-like design. It watches the push-side and
// pop-side handshakes, keeps its own copy of the words still outstanding and
// compares every popped word with the oldest one. Mismatch, underflow,
// overflow, head-of-queue timeout and data left over at end of test are
// reported through sticky flags, and a small state machine summarises the run
// as PASS or FAIL.
//
// Ports
//   i_clk               clock
//   i_rst               synchronous active-high reset
//   i_cg                clock gate; all state holds while low
//   i_pushData/i_pushed word accepted by the observed write side
//   i_popData/i_popped  word delivered by the observed read side
//   i_drain             end-of-stimulus request (pulse or level)
//   o_nPushed/o_nPopped saturating counts of accepted pushes / valid pops
//   o_occupancy         number of outstanding expected words
//   o_err*              sticky error flags
//   o_mismatchExpected  expected word of the first mismatch
//   o_mismatchActual    observed word of the first mismatch
//   o_done/o_pass       run finished / run finished cleanly
// ---------------------------------------------------------------------------
module fifo_order_checker #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int MAX_LATENCY = 256
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cg,
  input  logic [WIDTH-1:0]         i_pushData,
  input  logic                     i_pushed,
  input  logic [WIDTH-1:0]         i_popData,
  input  logic                     i_popped,
  input  logic                     i_drain,
  output logic [31:0]              o_nPushed,
  output logic [31:0]              o_nPopped,
  output logic [$clog2(DEPTH):0]   o_occupancy,
  output logic                     o_errMismatch,
  output logic                     o_errUnderflow,
  output logic                     o_errOverflow,
  output logic                     o_errTimeout,
  output logic                     o_errLeftover,
  output logic [WIDTH-1:0]         o_mismatchExpected,
  output logic [WIDTH-1:0]         o_mismatchActual,
  output logic                     o_done,
  output logic                     o_pass
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          PW      = AW + 1;
  localparam logic [31:0] MAX_LAT = 32'(MAX_LATENCY);

  typedef enum logic [1:0] {RUN, DRAIN, PASS, FAIL} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [31:0]      age;
  logic [31:0]      wait_cnt;

  logic             empty;
  logic             full;
  logic             push_ev;
  logic             pop_ev;
  logic             push_ok;
  logic             pop_ok;
  logic [WIDTH-1:0] head;
  logic             mismatch_ev;
  logic             underflow_ev;
  logic             overflow_ev;
  logic             timeout_ev;
  logic             leftover_ev;
  logic             err_any;
  logic             drained;

  // The extra pointer bit tells a full queue from an empty one.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  assign push_ev = i_cg & i_pushed;
  assign pop_ev  = i_cg & i_popped;

  // A pop from an empty queue has nothing to compare against, and a word
  // pushed in the same cycle is not yet poppable. A push into a full queue
  // is accepted only when a valid pop frees a slot in the same cycle.
  assign pop_ok       = pop_ev & ~empty;
  assign push_ok      = push_ev & (~full | pop_ok);
  assign underflow_ev = pop_ev & empty;
  assign overflow_ev  = push_ev & full & ~pop_ev;

  assign head         = mem[rptr[AW-1:0]];
  assign mismatch_ev  = pop_ok & (i_popData != head);

  assign timeout_ev   = (MAX_LATENCY > 0) && i_cg && (state == RUN) &&
                        (age >= MAX_LAT);

  // Errors raised this cycle count together with the sticky ones so that
  // the state machine reacts on the same edge the flag is set.
  assign err_any = mismatch_ev | underflow_ev | overflow_ev | timeout_ev |
                   o_errMismatch | o_errUnderflow | o_errOverflow |
                   o_errTimeout | o_errLeftover;

  // An empty queue only counts as drained if no new word arrives with it.
  assign drained = empty & ~push_ok;

  assign leftover_ev = i_cg && (state == DRAIN) && !err_any && !drained &&
                       (wait_cnt >= MAX_LAT);

  assign o_occupancy = wptr - rptr;

  // Storage for the expected words; contents are meaningless outside the
  // pointer window, so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wptr[AW-1:0]] <= i_pushData;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr               <= '0;
      rptr               <= '0;
      o_nPushed          <= '0;
      o_nPopped          <= '0;
      o_errMismatch      <= 1'b0;
      o_errUnderflow     <= 1'b0;
      o_errOverflow      <= 1'b0;
      o_errTimeout       <= 1'b0;
      o_errLeftover      <= 1'b0;
      o_mismatchExpected <= '0;
      o_mismatchActual   <= '0;
      age                <= '0;
      wait_cnt           <= '0;
      state              <= RUN;
      o_done             <= 1'b0;
      o_pass             <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;

      if (push_ok && (o_nPushed != '1)) o_nPushed <= o_nPushed + 32'd1;
      if (pop_ok  && (o_nPopped != '1)) o_nPopped <= o_nPopped + 32'd1;

      o_errMismatch  <= o_errMismatch  | mismatch_ev;
      o_errUnderflow <= o_errUnderflow | underflow_ev;
      o_errOverflow  <= o_errOverflow  | overflow_ev;
      o_errTimeout   <= o_errTimeout   | timeout_ev;
      o_errLeftover  <= o_errLeftover  | leftover_ev;

      // Only the first mismatch is captured; it is usually the root cause.
      if (mismatch_ev && !o_errMismatch) begin
        o_mismatchExpected <= head;
        o_mismatchActual   <= i_popData;
      end

      if (i_cg) begin
        // Age of the current head word: restarts whenever the head moves
        // or there is no head at all.
        if (pop_ev || empty) begin
          age <= '0;
        end else if (age != '1) begin
          age <= age + 32'd1;
        end

        case (state)
          RUN: begin
            if (err_any) begin
              state  <= FAIL;
              o_done <= 1'b1;
            end else if (i_drain) begin
              state    <= DRAIN;
              wait_cnt <= '0;
            end
          end
          DRAIN: begin
            if (err_any) begin
              state  <= FAIL;
              o_done <= 1'b1;
            end else if (drained) begin
              state  <= PASS;
              o_done <= 1'b1;
              o_pass <= 1'b1;
            end else if (wait_cnt >= MAX_LAT) begin
              state  <= FAIL;
              o_done <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 32'd1;
            end
          end
          PASS: begin
            if (err_any) begin
              state  <= FAIL;
              o_pass <= 1'b0;
            end
          end
          FAIL: begin
            state <= FAIL;
          end
          default: begin
            state  <= FAIL;
            o_done <= 1'b1;
            o_pass <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_order_checker.sv
// ---------------------------------------------------------------------------
// tb_fifo_order_checker
//
// Directed bench for fifo_order_checker (WIDTH=8, DEPTH=16, MAX_LATENCY=8).
// Each step drives one cycle of handshake activity, waits for the rising
// edge and samples the outputs 1 ns later against hand-computed values.
// ---------------------------------------------------------------------------
module tb_fifo_order_checker;

  localparam int WIDTH       = 8;
  localparam int DEPTH       = 16;
  localparam int MAX_LATENCY = 8;

  logic             clk;
  logic             rst;
  logic             cg;
  logic [WIDTH-1:0] push_data;
  logic             pushed;
  logic [WIDTH-1:0] pop_data;
  logic             popped;
  logic             drain;
  logic [31:0]      n_pushed;
  logic [31:0]      n_popped;
  logic [4:0]       occupancy;
  logic             err_mismatch;
  logic             err_underflow;
  logic             err_overflow;
  logic             err_timeout;
  logic             err_leftover;
  logic [WIDTH-1:0] mismatch_expected;
  logic [WIDTH-1:0] mismatch_actual;
  logic             done;
  logic             pass;

  int checks = 0;
  int errors = 0;

  fifo_order_checker #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .MAX_LATENCY(MAX_LATENCY)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_cg              (cg),
    .i_pushData        (push_data),
    .i_pushed          (pushed),
    .i_popData         (pop_data),
    .i_popped          (popped),
    .i_drain           (drain),
    .o_nPushed         (n_pushed),
    .o_nPopped         (n_popped),
    .o_occupancy       (occupancy),
    .o_errMismatch     (err_mismatch),
    .o_errUnderflow    (err_underflow),
    .o_errOverflow     (err_overflow),
    .o_errTimeout      (err_timeout),
    .o_errLeftover     (err_leftover),
    .o_mismatchExpected(mismatch_expected),
    .o_mismatchActual  (mismatch_actual),
    .o_done            (done),
    .o_pass            (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of activity: drive, take the edge, settle, then return the
  // handshake inputs to idle.
  task automatic applyStimulus(input logic do_push, input logic [7:0] pd,
                               input logic do_pop, input logic [7:0] qd,
                               input logic do_drain, input logic gate);
    pushed    = do_push;
    push_data = pd;
    popped    = do_pop;
    pop_data  = qd;
    drain     = do_drain;
    cg        = gate;
    @(posedge clk);
    #1;
    pushed = 1'b0;
    popped = 1'b0;
    drain  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    cg  = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Flags packed as {mismatch, underflow, overflow, timeout, leftover}.
  function automatic logic [31:0] flags();
    return {27'd0, err_mismatch, err_underflow, err_overflow, err_timeout, err_leftover};
  endfunction

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_npushed"}, n_pushed, 32'd0);
    checkOutput({tag, "_npopped"}, n_popped, 32'd0);
    checkOutput({tag, "_occ"}, {27'd0, occupancy}, 32'd0);
    checkOutput({tag, "_flags"}, flags(), 32'd0);
    checkOutput({tag, "_mm_exp"}, {24'd0, mismatch_expected}, 32'd0);
    checkOutput({tag, "_mm_act"}, {24'd0, mismatch_actual}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_pass"}, {31'd0, pass}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; cg = 1'b1; pushed = 1'b0; popped = 1'b0; drain = 1'b0;
    push_data = '0; pop_data = '0;

    // Reset state
    doReset();
    checkResetState("reset");

    // Ordered traffic: pushes cycles 0..2, pops 5..7, drain at 10
    applyStimulus(1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h22, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("ord_occ3", {27'd0, occupancy}, 32'd3);
    checkOutput("ord_npushed", n_pushed, 32'd3);
    idle(2);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 1'b1);
    checkOutput("ord_npopped", n_popped, 32'd3);
    checkOutput("ord_occ0", {27'd0, occupancy}, 32'd0);
    checkOutput("ord_flags", flags(), 32'd0);
    idle(2);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("ord_done_in_drain", {31'd0, done}, 32'd0);
    idle(1);
    checkOutput("ord_pass", {31'd0, pass}, 32'd1);
    checkOutput("ord_done", {31'd0, done}, 32'd1);

    // Mismatch capture
    doReset();
    checkResetState("reset2");
    applyStimulus(1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b1);
    checkOutput("mm_flag", {31'd0, err_mismatch}, 32'd1);
    checkOutput("mm_exp", {24'd0, mismatch_expected}, 32'hA5);
    checkOutput("mm_act", {24'd0, mismatch_actual}, 32'h5A);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b1);
    checkOutput("mm_exp_kept", {24'd0, mismatch_expected}, 32'hA5);
    checkOutput("mm_act_kept", {24'd0, mismatch_actual}, 32'h5A);
    checkOutput("mm_npopped", n_popped, 32'd2);
    checkOutput("mm_done", {31'd0, done}, 32'd1);
    checkOutput("mm_pass", {31'd0, pass}, 32'd0);

    // Overflow and wrap
    doReset();
    checkResetState("reset3");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i), 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("ovf_occ16", {27'd0, occupancy}, 32'd16);
    checkOutput("ovf_flag_before", {31'd0, err_overflow}, 32'd0);
    applyStimulus(1'b1, 8'h99, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("ovf_flag", {31'd0, err_overflow}, 32'd1);
    checkOutput("ovf_occ_after_drop", {27'd0, occupancy}, 32'd16);
    checkOutput("ovf_npushed_drop", n_pushed, 32'd16);
    applyStimulus(1'b1, 8'h77, 1'b1, 8'h00, 1'b0, 1'b1);
    checkOutput("ovf_occ_swap", {27'd0, occupancy}, 32'd16);
    checkOutput("ovf_npushed_swap", n_pushed, 32'd17);
    for (int i = 1; i < 16; i++) applyStimulus(1'b0, 8'h00, 1'b1, 8'(i), 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b1);
    checkOutput("ovf_occ_empty", {27'd0, occupancy}, 32'd0);
    checkOutput("ovf_no_mismatch", {31'd0, err_mismatch}, 32'd0);
    checkOutput("ovf_no_underflow", {31'd0, err_underflow}, 32'd0);
    checkOutput("ovf_npopped", n_popped, 32'd17);

    // Underflow with simultaneous push
    doReset();
    applyStimulus(1'b1, 8'h42, 1'b1, 8'h42, 1'b0, 1'b1);
    checkOutput("uf_flag", {31'd0, err_underflow}, 32'd1);
    checkOutput("uf_occ", {27'd0, occupancy}, 32'd1);
    checkOutput("uf_npopped", n_popped, 32'd0);
    checkOutput("uf_npushed", n_pushed, 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h42, 1'b0, 1'b1);
    checkOutput("uf_stored_ok", {31'd0, err_mismatch}, 32'd0);
    checkOutput("uf_occ0", {27'd0, occupancy}, 32'd0);

    // Clock gate and timeout
    doReset();
    applyStimulus(1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h66, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 19; i++) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("cg_occ_held", {27'd0, occupancy}, 32'd1);
    checkOutput("cg_no_timeout", {31'd0, err_timeout}, 32'd0);
    idle(8);
    checkOutput("to_not_yet", {31'd0, err_timeout}, 32'd0);
    idle(1);
    checkOutput("to_flag", {31'd0, err_timeout}, 32'd1);
    checkOutput("to_done", {31'd0, done}, 32'd1);

    // Leftover at drain, then reset
    doReset();
    applyStimulus(1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h02, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    idle(8);
    checkOutput("lo_not_yet", {31'd0, err_leftover}, 32'd0);
    checkOutput("lo_done_not_yet", {31'd0, done}, 32'd0);
    idle(1);
    checkOutput("lo_flag", {31'd0, err_leftover}, 32'd1);
    checkOutput("lo_done", {31'd0, done}, 32'd1);
    checkOutput("lo_pass", {31'd0, pass}, 32'd0);
    checkOutput("lo_occ", {27'd0, occupancy}, 32'd1);
    doReset();
    checkResetState("reset_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
